dcache_mem_bridge: RTL and testbench
====================================

// Module: dcache_mem_bridge
// PURPOSE
//  Memory-side stage directly downstream of dcache_top. Consumes the cache's line
//  miss/writeback requests (req/wr/daddr/dirty_data) and converts them into 32-bit
//  single-word accesses on a synchronous SRAM port with a ready-based stall.
//  Returns refill beats (valid/data) and completion pulses (rd_done/wr_done).
// PARAMETERS
//  AW   20  byte address width of daddr and mem_addr
//  NUM  4   words per cache line; power of 2, >=2; line = NUM*32 bits
// PORTS
//  clk         in   1       single clock, rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  req         in   1       line request from cache; held until rd_done/wr_done
//  wr          in   1       1 = writeback dirty_data, 0 = refill; valid with req
//  daddr       in   AW      miss/victim byte address; word offset used only under CWF
//  dirty_data  in   NUM*32  victim line; word i = dirty_data[32*i+31:32*i]
//  valid       out  1       refill beat valid on data (one beat per cycle)
//  data        out  32      refill word
//  rd_done     out  1       1-cycle pulse, coincides with last refill beat
//  wr_done     out  1       1-cycle pulse after last write accepted
//  mem_cs      out  1       SRAM access request
//  mem_we      out  1       1 = write, 0 = read; valid with mem_cs
//  mem_addr    out  AW      word-aligned byte address ([1:0]=0)
//  mem_wdata   out  32      write data
//  mem_ready   in   1       access accepted when mem_cs & mem_ready
//  mem_rdata   in   32      read data, valid the cycle after an accepted read
// BEHAVIOUR
//  - Reset: state IDLE, counters 0; valid, data, rd_done, wr_done, mem_cs, mem_we,
//    mem_addr, mem_wdata all 0. Async reset mid-operation aborts the transfer;
//    in-flight read data is dropped, no done pulse; cache re-issues after reset.
//  - FSM IDLE->WRITE (req&wr) | READ (req&~wr); WRITE->DONE; READ->DRAIN->DONE; DONE->IDLE.
//  - IDLE: on req, register line base {daddr[AW-1:log2(NUM*4)],0}, dirty_data, wr.
//    req ignored in WRITE/READ/DRAIN/DONE (no re-acceptance of a held req).
//  - WRITE: mem_cs=1, mem_we=1, word i = beat counter (0..NUM-1); mem_addr/mem_wdata
//    registered, advance only on mem_cs&mem_ready. After beat NUM-1 accepted: mem_cs=0,
//    enter DONE with wr_done=1 for exactly that cycle.
//  - READ: mem_cs=1, mem_we=0, issue NUM reads, advance on mem_ready; after last
//    accepted -> DRAIN (mem_cs=0). Each accepted read at cycle n: mem_rdata sampled
//    n+1, registered onto data with valid=1 at n+2. Last beat: rd_done=1 same cycle,
//    state DONE. Beats delivered strictly in issue order, never more than NUM.
//  - Latency, mem_ready=1, req seen cycle 0: writes at 1..4, wr_done at 5;
//    reads at 1..4, valid at 3..6, rd_done at 6. Earliest next accept: 1 cycle after DONE.
//  - mem_ready low stalls issue only; returned data is never stalled (no backpressure on valid).
//  - Beat counter wraps modulo NUM; address word field = (start + count) mod NUM.
//  - valid low between beats when mem_ready stalls; data holds last value when valid=0.
// CONFIGURATION
//  DCACHE_CWF_EN defined: refill is critical-word-first; start word = daddr[log2(NUM)+1:2],
//   wrapping within the line (e.g. start 2, NUM 4: 2,3,0,1). Writebacks always start at 0.
//  DCACHE_CWF_EN undefined: refills always start at word 0; daddr word offset ignored.
// TESTING
//  1 Writeback: req=1,wr=1,daddr=0x00120,dirty_data={W3..W0}={0xD3,0xD2,0xD1,0xD0},
//    mem_ready=1 -> mem_addr 0x120,0x124,0x128,0x12C with D0..D3 at cycles 1-4; wr_done cycle 5 only.
//  2 Refill: req=1,wr=0,daddr=0x00340, SRAM word k=0xA000_0000+k -> valid cycles 3-6,
//    data in address order 0x340..0x34C, rd_done with 4th beat only.
//  3 Stall: refill with mem_ready toggling 1,0,0,1,1,0,1 -> exactly 4 valid beats, correct order,
//    mem_addr held during stalls, rd_done on last beat.
//  4 Reset mid-refill: assert reset_n=0 after 2nd beat -> all outputs 0 immediately, no rd_done;
//    new refill after release completes normally with 4 beats.
//  5 Held req: cache keeps req=1 through DONE cycle -> no second transfer; req pulsed again in
//    IDLE -> new transfer starts.
//  6 DCACHE_CWF_EN: refill daddr=0x00348 -> read order 0x348,0x34C,0x340,0x344; without macro 0x340 first.

Source files
------------

// File: rtl/dcache_mem_bridge.sv
// rtl/dcache_mem_bridge.sv - dcache line requests to single-word synchronous SRAM accesses
//
// Purpose: takes a line refill/writeback request from dcache_top and sequences NUM
// 32-bit SRAM accesses, stalling on mem_ready. Refill words come back as valid/data
// beats. Completion is signalled with a one-cycle rd_done or wr_done pulse.
// Optional feature: define DCACHE_CWF_EN for critical-word-first refills.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req, wr, daddr, dirty_data line request from the cache (held until done)
//   valid, data                refill beats, one word per beat
//   rd_done, wr_done           completion pulses
//   mem_cs, mem_we, mem_addr,
//   mem_wdata                  SRAM access request (registered)
//   mem_ready, mem_rdata       SRAM accept and read data (data arrives 1 cycle after accept)
module dcache_mem_bridge #(
  parameter int AW  = 20,
  parameter int NUM = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              wr,
  input  logic [AW-1:0]     daddr,
  input  logic [NUM*32-1:0] dirty_data,
  output logic              valid,
  output logic [31:0]       data,
  output logic              rd_done,
  output logic              wr_done,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam int LW = $clog2(NUM);
  localparam int OW = LW + 2;  // byte-offset bits within one line

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [AW-OW-1:0]  line_tag;
  logic [NUM*32-1:0] line_buf;
  logic [LW-1:0]     start_word;
  logic [LW-1:0]     issue_cnt;
  logic [LW-1:0]     ret_cnt;
  logic              rd_pend;   // a read was accepted last cycle; mem_rdata is valid now

  logic [LW-1:0]     req_start;
  logic [LW-1:0]     next_cnt;
  logic [LW-1:0]     next_word;
  logic              last_issue;
  logic              last_ret;

`ifdef DCACHE_CWF_EN
  // Refills begin at the missed word; writebacks always begin at word 0.
  assign req_start = wr ? '0 : daddr[OW-1:2];
`else
  assign req_start = '0;
`endif

  // The low address bits only matter for critical-word-first.
  logic unused_daddr_lsb;
  assign unused_daddr_lsb = &{1'b0, daddr[OW-1:0]};

  // The word counters are LW bits wide, so start + count wraps within the line.
  assign next_cnt   = issue_cnt + 1'b1;
  assign next_word  = start_word + next_cnt;
  assign last_issue = (issue_cnt == LW'(NUM - 1));
  assign last_ret   = (ret_cnt == LW'(NUM - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      line_tag   <= '0;
      line_buf   <= '0;
      start_word <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      rd_pend    <= 1'b0;
      valid      <= 1'b0;
      data       <= '0;
      rd_done    <= 1'b0;
      wr_done    <= 1'b0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      rd_pend <= 1'b0;

      // The return path never stalls: each accepted read lands on data two
      // cycles after its accept, regardless of what the issue side is doing.
      valid <= rd_pend;
      if (rd_pend) begin
        data    <= mem_rdata;
        ret_cnt <= ret_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (req) begin
            line_tag   <= daddr[AW-1:OW];
            line_buf   <= dirty_data;
            start_word <= req_start;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            mem_cs     <= 1'b1;
            mem_we     <= wr;
            mem_addr   <= {daddr[AW-1:OW], req_start, 2'b00};
            if (wr) begin
              mem_wdata <= dirty_data[31:0];
            end
            state <= wr ? S_WRITE : S_READ;
          end
        end

        S_WRITE, S_READ: begin
          // mem_cs is high throughout these states, so mem_ready alone means accept.
          if (mem_ready) begin
            issue_cnt <= next_cnt;
            if (state == S_READ) begin
              rd_pend <= 1'b1;
            end
            if (last_issue) begin
              mem_cs <= 1'b0;
              mem_we <= 1'b0;
              if (state == S_WRITE) begin
                wr_done <= 1'b1;
                state   <= S_DONE;
              end else begin
                state <= S_DRAIN;
              end
            end else begin
              mem_addr <= {line_tag, next_word, 2'b00};
              if (state == S_WRITE) begin
                mem_wdata <= line_buf[32*int'(next_word) +: 32];
              end
            end
          end
        end

        S_DRAIN: begin
          // Only the final read is still outstanding here.
          if (rd_pend && last_ret) begin
            rd_done <= 1'b1;
            state   <= S_DONE;
          end
        end

        // A req still held high from the finished transfer is not looked at here.
        // The bridge only accepts again once it is back in IDLE.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// tb/tb_dcache_mem_bridge.sv - self-checking bench for dcache_mem_bridge
module tb_dcache_mem_bridge;

  localparam int AW   = 20;
  localparam int NUM  = 4;
  localparam int LW   = $clog2(NUM);
  localparam int PATN = 160;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req = 1'b0;
  logic              wr = 1'b0;
  logic [AW-1:0]     daddr = '0;
  logic [NUM*32-1:0] dirty_data = '0;
  logic              valid;
  logic [31:0]       data;
  logic              rd_done;
  logic              wr_done;
  logic              mem_cs;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready = 1'b0;
  logic [31:0]       mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] salt = '0;
  bit rdy_pat [PATN];

  dcache_mem_bridge #(.AW(AW), .NUM(NUM)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .daddr(daddr),
    .dirty_data(dirty_data), .valid(valid), .data(data), .rd_done(rd_done),
    .wr_done(wr_done), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM contents are a pure function of address (and a per-transfer salt).
  function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
    return (32'hA000_0000 + 32'(a >> 2)) ^ salt;
  endfunction

  // Read data is returned the cycle after an accept; otherwise the bus carries junk.
  always @(posedge clk) begin
    if (mem_cs && mem_ready && !mem_we) mem_rdata <= mem_val(mem_addr);
    else                                mem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_ready(input int mode);
    for (int c = 0; c < PATN; c++) begin
      if (mode == 2 && c < 60) rdy_pat[c] = ($urandom_range(0, 9) < 6);
      else                     rdy_pat[c] = 1'b1;
    end
    if (mode == 1) begin
      // ready sequence 1,0,0,1,1,0,1 over cycles 1..7
      rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b0; rdy_pat[6] = 1'b0;
    end
  endtask

  // Runs one line transfer starting at a negedge. Expected behaviour is derived from
  // the ready pattern: the k-th accept happens on the k-th ready cycle from cycle 1,
  // refill beats follow their accepts by 2 cycles, done follows the last accept.
  task automatic run_xfer(input logic t_wr, input logic [AW-1:0] t_addr,
                          input logic [NUM*32-1:0] t_line, input bit held,
                          input logic [AW-1:0] tbl_first, input int tbl_done);
    logic [AW-1:0] base;
    logic [AW-1:0] ea [NUM];
    int acc_cyc [NUM];
    int start, n, last_acc, done_c, k, bi;
    bit ev;
    base = t_addr & ~(AW'(NUM * 4 - 1));
    start = 0;
`ifdef DCACHE_CWF_EN
    if (!t_wr) start = int'(t_addr[LW+1:2]);
`endif
    for (int i = 0; i < NUM; i++) ea[i] = base + AW'(((start + i) % NUM) * 4);
    for (int i = 0; i < NUM; i++) acc_cyc[i] = PATN;
    n = 0;
    for (int c = 1; c < PATN; c++) begin
      if (rdy_pat[c] && n < NUM) begin
        acc_cyc[n] = c;
        n++;
      end
    end
    last_acc = acc_cyc[NUM-1];
    done_c = t_wr ? last_acc + 1 : last_acc + 2;

    req = 1'b1; wr = t_wr; daddr = t_addr; dirty_data = t_line; mem_ready = rdy_pat[0];
    for (int c = 1; c <= done_c + 5; c++) begin
      @(negedge clk);
      mem_ready = rdy_pat[c];
      k = 0;
      for (int i = 0; i < NUM; i++) if (acc_cyc[i] < c) k++;
      chk("mem_cs", mem_cs, c <= last_acc);
      if (mem_cs && k < NUM) begin
        chk("mem_we", mem_we, t_wr);
        chk("mem_addr", mem_addr, ea[k]);
        if (t_wr) chk("mem_wdata", mem_wdata, t_line[32*k +: 32]);
      end
      ev = 1'b0;
      bi = -1;
      for (int i = 0; i < NUM; i++) begin
        if (!t_wr && acc_cyc[i] + 2 == c) ev = 1'b1;
        if (!t_wr && acc_cyc[i] + 2 <= c) bi = i;
      end
      chk("valid", valid, ev);
      if (bi >= 0) chk("data", data, mem_val(ea[bi]));
      chk("rd_done", rd_done, !t_wr && c == done_c);
      chk("wr_done", wr_done, t_wr && c == done_c);
      if (tbl_done > 0) begin
        if (c == 1) chk("tbl_first_addr", mem_addr, tbl_first);
        if (c == tbl_done) chk("tbl_done_cycle", t_wr ? wr_done : rd_done, 1);
      end
      if (c == (held ? done_c + 1 : done_c)) req = 1'b0;
    end
  endtask

  typedef struct {
    logic              wr;
    logic [AW-1:0]     daddr;
    logic [NUM*32-1:0] line;
    int                pat;
    bit                held;
    logic [AW-1:0]     first;
    int                done;
  } vec_t;

  vec_t tbl [7];
  int nb;

  initial begin
    tbl[0] = '{1'b1, 20'h00120, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0, 1'b0, 20'h00120, 5};
    tbl[1] = '{1'b0, 20'h00340, '0, 0, 1'b0, 20'h00340, 6};
    tbl[2] = '{1'b0, 20'h00340, '0, 1, 1'b0, 20'h00340, 9};
`ifdef DCACHE_CWF_EN
    tbl[3] = '{1'b0, 20'h00348, '0, 0, 1'b0, 20'h00348, 6};
    tbl[5] = '{1'b0, 20'h12344, '0, 0, 1'b1, 20'h12344, 6};
`else
    tbl[3] = '{1'b0, 20'h00348, '0, 0, 1'b0, 20'h00340, 6};
    tbl[5] = '{1'b0, 20'h12344, '0, 0, 1'b1, 20'h12340, 6};
`endif
    tbl[4] = '{1'b1, 20'h0034C, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 1'b0, 20'h00340, 8};
    tbl[6] = '{1'b1, 20'hFFFF0, {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000},
               0, 1'b1, 20'hFFFF0, 5};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {valid, rd_done, wr_done, mem_cs, mem_we}, 0);
    chk("rst_data", data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed table
    for (int v = 0; v < 7; v++) begin
      salt = '0;
      fill_ready(tbl[v].pat);
      run_xfer(tbl[v].wr, tbl[v].daddr, tbl[v].line, tbl[v].held, tbl[v].first, tbl[v].done);
    end

    // reset in the middle of a refill, after the second beat
    salt = '0;
    fill_ready(0);
    req = 1'b1; wr = 1'b0; daddr = 20'h00340; mem_ready = 1'b1;
    nb = 0;
    for (int c = 1; c <= 20 && nb < 2; c++) begin
      @(negedge clk);
      if (valid) nb++;
    end
    chk("rst_mid_two_beats", nb, 2);
    reset_n = 1'b0;
    req = 1'b0;
    #1;
    chk("rst_mid_ctrl", {valid, rd_done, wr_done, mem_cs, mem_we}, 0);
    chk("rst_mid_data", data, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_mem_wdata", mem_wdata, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_quiet", {valid, rd_done, mem_cs}, 0);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {valid, rd_done, mem_cs}, 0);
    end
    run_xfer(1'b0, 20'h00340, '0, 1'b0, 20'h00340, 6);

    // randomized transfers
    for (int r = 0; r < 30; r++) begin
      logic [NUM*32-1:0] line;
      for (int i = 0; i < NUM; i++) line[32*i +: 32] = $urandom;
      salt = $urandom;
      fill_ready(2);
      run_xfer(1'($urandom_range(0, 1)), AW'($urandom), line, 1'($urandom_range(0, 1)), '0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
